// File: rtl/canon_pkg.sv
// Shared types and helpers for the canon sequencer and its display/bench models.
package canon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_FETCH   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_ISSUE   = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam int unsigned NOTE_REST = 0;

  // Melody position a voice plays at a given beat: voices trail by v*entry_beats, wrapping at the song length.
  function automatic int unsigned voice_addr(input int unsigned beat,
                                             input int unsigned v,
                                             input int unsigned entry_beats,
                                             input int unsigned addr_w);
    int unsigned mask;
    mask = (32'd1 << addr_w) - 32'd1;
    return (beat - v * entry_beats) & mask;
  endfunction

endpackage

// File: rtl/canon_sequencer.sv
// Beat-driven scheduler: per crotchet, fetches each active voice's delayed note
// from the melody ROM and hands it to the tone-generator config port.
module canon_sequencer
  import canon_pkg::*;
#(
  parameter int unsigned NUM_VOICES  = 4,
  parameter int unsigned ENTRY_BEATS = 8,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned NOTE_W      = 8,
  localparam int unsigned VW         = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  beat_tick,
  output logic                  rom_rd,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [NOTE_W-1:0]     rom_data,
  output logic                  cfg_valid,
  input  logic                  cfg_ready,
  output logic [VW-1:0]         cfg_voice,
  output logic [NOTE_W-1:0]     cfg_note,
  output logic [ADDR_W-1:0]     beat,
  output logic [NUM_VOICES-1:0] voices_active,
  output logic                  busy,
  output logic                  overrun
);

  // Parameter sanity: a voice entering after the song has wrapped would never line up.
  if (NUM_VOICES < 1 || NUM_VOICES > 8) begin : g_bad_voices
    $error("canon_sequencer: NUM_VOICES must be in 1..8");
  end
  if ((NUM_VOICES - 1) * ENTRY_BEATS >= (32'd1 << ADDR_W)) begin : g_bad_entry
    $error("canon_sequencer: last voice entry must fall inside the song");
  end

  state_e                  state, state_d;
  logic                    pending, pending_d;
  logic [VW-1:0]           vptr, vptr_d;
  logic [ADDR_W-1:0]       beat_d, rom_addr_d;
  logic [NUM_VOICES-1:0]   active_d, entry_mask;
  logic                    overrun_d, rom_rd_d, cfg_valid_d, busy_d;
  logic [VW-1:0]           cfg_voice_d;
  logic [NOTE_W-1:0]       cfg_note_d;
  logic [VW:0]             first_hit, next_hit;

  // Lowest set bit of mask at or above index lo; MSB of result flags a hit.
  function automatic logic [VW:0] find_from(input logic [NUM_VOICES-1:0] mask,
                                            input int unsigned lo);
    logic [VW:0] hit;
    hit = '0;
    for (int i = int'(NUM_VOICES) - 1; i >= 0; i--) begin
      if (mask[i] && (32'(i) >= lo)) hit = {1'b1, VW'(i)};
    end
    return hit;
  endfunction

  // Voices whose entry beat is the current beat, and the priority finders over the mask.
  always_comb begin
    entry_mask = '0;
    for (int v = 0; v < int'(NUM_VOICES); v++) begin
      entry_mask[v] = (32'(beat) == 32'(v) * ENTRY_BEATS);
    end
    first_hit = find_from(voices_active | entry_mask, 32'd0);
    next_hit  = find_from(voices_active, 32'(vptr) + 32'd1);
  end

  // Next-state and next-output logic for the sweep FSM.
  always_comb begin
    state_d     = state;
    beat_d      = beat;
    active_d    = voices_active;
    pending_d   = pending;
    overrun_d   = overrun;
    vptr_d      = vptr;
    rom_addr_d  = rom_addr;
    cfg_voice_d = cfg_voice;
    cfg_note_d  = cfg_note;
    rom_rd_d    = 1'b0;
    cfg_valid_d = 1'b0;
    busy_d      = 1'b0;

    // A tick arriving mid-sweep is queued once; a second one is dropped and flagged.
    if (state != ST_IDLE && beat_tick) begin
      if (pending) overrun_d = 1'b1;
      else         pending_d = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (enable && (beat_tick || pending)) begin
          state_d   = ST_START;
          pending_d = 1'b0;
        end
      end
      ST_START: begin
        active_d = voices_active | entry_mask;
        if (first_hit[VW]) begin
          vptr_d  = first_hit[VW-1:0];
          state_d = ST_FETCH;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_FETCH: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        cfg_note_d  = rom_data;
        cfg_voice_d = vptr;
        state_d     = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (cfg_ready) begin
          if (next_hit[VW]) begin
            vptr_d  = next_hit[VW-1:0];
            state_d = ST_FETCH;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        beat_d  = beat + ADDR_W'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobes and address are registered against the state being entered.
    rom_rd_d    = (state_d == ST_FETCH);
    cfg_valid_d = (state_d == ST_ISSUE);
    busy_d      = (state_d != ST_IDLE);
    if (state_d == ST_FETCH) begin
      rom_addr_d = ADDR_W'(voice_addr(32'(beat), 32'(vptr_d), ENTRY_BEATS, ADDR_W));
    end
  end

  // State and output registers; reset aborts any sweep immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      beat          <= '0;
      voices_active <= '0;
      pending       <= 1'b0;
      overrun       <= 1'b0;
      vptr          <= '0;
      rom_rd        <= 1'b0;
      rom_addr      <= '0;
      cfg_valid     <= 1'b0;
      cfg_voice     <= '0;
      cfg_note      <= '0;
      busy          <= 1'b0;
    end else begin
      state         <= state_d;
      beat          <= beat_d;
      voices_active <= active_d;
      pending       <= pending_d;
      overrun       <= overrun_d;
      vptr          <= vptr_d;
      rom_rd        <= rom_rd_d;
      rom_addr      <= rom_addr_d;
      cfg_valid     <= cfg_valid_d;
      cfg_voice     <= cfg_voice_d;
      cfg_note      <= cfg_note_d;
      busy          <= busy_d;
    end
  end

endmodule
